// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Derives a pixel-rate enable from normalCLK, runs the horizontal and vertical
// position counters, and decodes sync, blanking and line/frame strobes.
// The decoded outputs are registered from the next-state counter values, so
// they always match the HControl/VControl values presented with them.

module vga_timing_gen #(
  parameter int CNT_W     = 16,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_W   = 8
) (
  input  logic               normalCLK,
  input  logic               resetN,
  input  logic               enable,
  output logic               pixel_tick,
  output logic [CNT_W-1:0]   HControl,
  output logic [CNT_W-1:0]   VControl,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Reject geometry that cannot be represented or makes no sense
  if (CLK_DIV < 1 || H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_geometry
    $error("vga_timing_gen: CLK_DIV and every porch/sync/visible width must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q;
  logic             advance;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  assign advance = enable && (div_q == DIV_LAST);
  assign h_wrap  = (HControl == H_LAST);
  assign v_wrap  = (VControl == V_LAST);

  // Next raster position: step one pixel on advance, V steps only at the H wrap
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    h_next = HControl;
    v_next = VControl;
    if (advance) begin
      h_next = h_wrap ? '0 : HControl + CNT_W'(1);
      if (h_wrap) begin
        v_next = v_wrap ? '0 : VControl + CNT_W'(1);
      end
    end
  end

  // Pixel-clock divider; pixel_tick marks the cycle after each pixel advance
  always_ff @(posedge normalCLK or negedge resetN) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetN) begin
      div_q      <= '0;
      pixel_tick <= 1'b0;
    end else begin
      pixel_tick <= advance;
      if (enable) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end
    end
  end

  // Raster position counters
  always_ff @(posedge normalCLK or negedge resetN) begin
    if (!resetN) begin
      HControl <= '0;
      VControl <= '0;
    end else begin
      HControl <= h_next;
      VControl <= v_next;
    end
  end

  // Sync and blanking decode from the next position, aligned with the counters
  always_ff @(posedge normalCLK or negedge resetN) begin
    if (!resetN) begin
      hsync    <= ~HSYNC_POL;
      vsync    <= ~VSYNC_POL;
      video_on <= 1'b1;
    end else begin
      hsync    <= (h_next >= H_SYNC_FIRST && h_next <= H_SYNC_LAST) ? HSYNC_POL : ~HSYNC_POL;
      vsync    <= (v_next >= V_SYNC_FIRST && v_next <= V_SYNC_LAST) ? VSYNC_POL : ~VSYNC_POL;
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  // Line/frame strobes last one pixel period; frame counter bumps on entry to (0,0)
  always_ff @(posedge normalCLK or negedge resetN) begin
    if (!resetN) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (advance) begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Instance a: default 800x525 geometry, CLK_DIV=1, active-low syncs.
// Instance b: 8x6 geometry, CLK_DIV=4, active-high syncs, 2-bit frame counter.
// The reference model maps "pixels elapsed since reset" straight to the
// expected raster position and decoded outputs with plain arithmetic.

module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    bit hp, vp;
    int fw;
  } geom_t;

  typedef struct {
    int h, v;
    bit hs, vs, vo, ls, fs;
    int fc;
  } exp_t;

  typedef struct {
    int k;   // enabled clocks since reset release
    int h, v;
    bit hs, vo, ls;
  } vec_t;

  localparam int DIV_A = 1;
  localparam int DIV_B = 4;
  localparam geom_t G_A = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33,
                            hp:1'b0, vp:1'b0, fw:8};
  localparam geom_t G_B = '{hv:4, hf:1, hs:2, hb:1, vv:3, vf:1, vs:1, vb:1,
                            hp:1'b1, vp:1'b1, fw:2};

  logic normalCLK = 1'b0;
  logic resetN    = 1'b0;
  logic en_a      = 1'b0;
  logic en_b      = 1'b0;

  logic        a_tick, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [15:0] a_h, a_v;
  logic [7:0]  a_fc;
  logic        b_tick, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [15:0] b_h, b_v;
  logic [1:0]  b_fc;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // reference state: enabled-clock counts and expected pixel_tick
  int e_a, e_b;
  bit tk_a, tk_b;

  vga_timing_gen #(
    .CNT_W(16), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(DIV_A), .FRAME_W(8)
  ) dut_a (
    .normalCLK(normalCLK), .resetN(resetN), .enable(en_a),
    .pixel_tick(a_tick), .HControl(a_h), .VControl(a_v),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CNT_W(16), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(DIV_B), .FRAME_W(2)
  ) dut_b (
    .normalCLK(normalCLK), .resetN(resetN), .enable(en_b),
    .pixel_tick(b_tick), .HControl(b_h), .VControl(b_v),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  always #5 normalCLK = ~normalCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected outputs after n pixel periods have elapsed since reset
  function automatic exp_t model(input geom_t g, input int n);
    exp_t m;
    int ht = g.hv + g.hf + g.hs + g.hb;
    int vt = g.vv + g.vf + g.vs + g.vb;
    m.h  = n % ht;
    m.v  = (n / ht) % vt;
    m.fc = (n / (ht * vt)) % (1 << g.fw);
    m.hs = (m.h >= g.hv + g.hf && m.h < g.hv + g.hf + g.hs) ? g.hp : !g.hp;
    m.vs = (m.v >= g.vv + g.vf && m.v < g.vv + g.vf + g.vs) ? g.vp : !g.vp;
    m.vo = (m.h < g.hv) && (m.v < g.vv);
    m.ls = (n > 0) && (m.h == 0);
    m.fs = (n > 0) && (m.h == 0) && (m.v == 0);
    return m;
  endfunction

  // Count enabled clocks; a pixel elapses every DIV enabled clocks
  always @(posedge normalCLK or negedge resetN) begin
    if (!resetN) begin
      e_a  <= 0;
      e_b  <= 0;
      tk_a <= 1'b0;
      tk_b <= 1'b0;
    end else begin
      if (en_a) begin
        e_a  <= e_a + 1;
        tk_a <= ((e_a + 1) % DIV_A) == 0;
      end else begin
        tk_a <= 1'b0;
      end
      if (en_b) begin
        e_b  <= e_b + 1;
        tk_b <= ((e_b + 1) % DIV_B) == 0;
      end else begin
        tk_b <= 1'b0;
      end
    end
  end

  // Compare every output of both instances against the model each cycle
  always @(negedge normalCLK) begin
    exp_t ea, eb;
    if (resetN && chk_on) begin
      ea = model(G_A, e_a / DIV_A);
      eb = model(G_B, e_b / DIV_B);
      check("a.tick", a_tick, tk_a);
      check("a.H",    a_h,    ea.h);
      check("a.V",    a_v,    ea.v);
      check("a.hsync", a_hs,  ea.hs);
      check("a.vsync", a_vs,  ea.vs);
      check("a.video_on", a_vo, ea.vo);
      check("a.line_start", a_ls, ea.ls);
      check("a.frame_start", a_fs, ea.fs);
      check("a.frame_count", a_fc, ea.fc);
      check("b.tick", b_tick, tk_b);
      check("b.H",    b_h,    eb.h);
      check("b.V",    b_v,    eb.v);
      check("b.hsync", b_hs,  eb.hs);
      check("b.vsync", b_vs,  eb.vs);
      check("b.video_on", b_vo, eb.vo);
      check("b.line_start", b_ls, eb.ls);
      check("b.frame_start", b_fs, eb.fs);
      check("b.frame_count", b_fc, eb.fc);
    end
  end

  // Random run/freeze pattern for instance b
  initial begin
    en_b = 1'b0;
    wait (resetN === 1'b1);
    forever begin
      @(negedge normalCLK);
      en_b = ($urandom % 8) != 0;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ea(input int target, input string name);
    for (int c = 0; c < 20000 && e_a < target; c++) @(negedge normalCLK);
    check(name, e_a, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " a.H"}, a_h, 0);
    check({tag, " a.V"}, a_v, 0);
    check({tag, " a.tick"}, a_tick, 0);
    check({tag, " a.hsync"}, a_hs, 1);
    check({tag, " a.vsync"}, a_vs, 1);
    check({tag, " a.video_on"}, a_vo, 1);
    check({tag, " a.line_start"}, a_ls, 0);
    check({tag, " a.frame_start"}, a_fs, 0);
    check({tag, " a.frame_count"}, a_fc, 0);
    check({tag, " b.hsync"}, b_hs, 0);
    check({tag, " b.vsync"}, b_vs, 0);
    check({tag, " b.video_on"}, b_vo, 1);
    check({tag, " b.frame_count"}, b_fc, 0);
  endtask

  vec_t tbl[12];

  initial begin
    int target;
    int b_n;

    // Checkpoints on instance a, hand-derived from the 800-pixel line geometry
    tbl[0]  = '{k:1,    h:1,   v:0, hs:1, vo:1, ls:0};
    tbl[1]  = '{k:639,  h:639, v:0, hs:1, vo:1, ls:0};
    tbl[2]  = '{k:640,  h:640, v:0, hs:1, vo:0, ls:0};
    tbl[3]  = '{k:655,  h:655, v:0, hs:1, vo:0, ls:0};
    tbl[4]  = '{k:656,  h:656, v:0, hs:0, vo:0, ls:0};
    tbl[5]  = '{k:751,  h:751, v:0, hs:0, vo:0, ls:0};
    tbl[6]  = '{k:752,  h:752, v:0, hs:1, vo:0, ls:0};
    tbl[7]  = '{k:799,  h:799, v:0, hs:1, vo:0, ls:0};
    tbl[8]  = '{k:800,  h:0,   v:1, hs:1, vo:1, ls:1};
    tbl[9]  = '{k:801,  h:1,   v:1, hs:1, vo:1, ls:0};
    tbl[10] = '{k:1440, h:640, v:1, hs:1, vo:0, ls:0};
    tbl[11] = '{k:1600, h:0,   v:2, hs:1, vo:1, ls:1};

    // Reset state
    resetN = 1'b0;
    en_a   = 1'b0;
    repeat (3) @(negedge normalCLK);
    check_reset_values("reset");

    // Release between edges, then run instance a continuously
    #2 resetN = 1'b1;
    en_a   = 1'b1;
    chk_on = 1'b1;

    foreach (tbl[i]) begin
      wait_ea(tbl[i].k, "tbl reach");
      check($sformatf("tbl[%0d] H", i), a_h, tbl[i].h);
      check($sformatf("tbl[%0d] V", i), a_v, tbl[i].v);
      check($sformatf("tbl[%0d] hsync", i), a_hs, tbl[i].hs);
      check($sformatf("tbl[%0d] video_on", i), a_vo, tbl[i].vo);
      check($sformatf("tbl[%0d] line_start", i), a_ls, tbl[i].ls);
    end

    // Instance b: frame counter wraps 3 -> 0 on the 4th frame (48 pixels/frame)
    for (int c = 0; c < 20000; c++) begin
      b_n = e_b / DIV_B;
      if (b_n % 192 == 191) break;
      @(negedge normalCLK);
    end
    check("b pre-wrap reach", (e_b / DIV_B) % 192, 191);
    check("b pre-wrap frame_count", b_fc, 3);
    for (int c = 0; c < 20000; c++) begin
      b_n = e_b / DIV_B;
      if (b_n % 192 == 0) break;
      @(negedge normalCLK);
    end
    check("b wrap reach", (e_b / DIV_B) % 192, 0);
    check("b wrap frame_count", b_fc, 0);
    check("b wrap frame_start", b_fs, 1);
    check("b wrap line_start", b_ls, 1);
    check("b wrap H", b_h, 0);
    check("b wrap V", b_v, 0);

    // Freeze instance a for 10 clocks at H=700 of the next line
    target = ((e_a / 800) + 1) * 800 + 700;
    wait_ea(target, "freeze reach");
    en_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge normalCLK);
      check("freeze H", a_h, 700);
      check("freeze V", a_v, (target / 800) % 525);
      check("freeze tick", a_tick, 0);
      check("freeze hsync", a_hs, 0);
    end
    en_a = 1'b1;
    @(negedge normalCLK);
    check("resume H", a_h, 701);
    check("resume tick", a_tick, 1);

    // Asynchronous reset in the middle of hsync
    target = ((e_a / 800) + 1) * 800 + 700;
    wait_ea(target, "reset reach");
    check("pre-reset hsync", a_hs, 0);
    check("pre-reset H", a_h, 700);
    #2 resetN = 1'b0;
    #1 check_reset_values("async reset");
    repeat (2) @(negedge normalCLK);
    check_reset_values("held reset");
    #2 resetN = 1'b1;

    // Random freeze/run on both instances after release; no frame_start until a full frame
    for (int c = 0; c < 1500; c++) begin
      @(negedge normalCLK);
      if (e_a < 800 * 525) check("no frame_start after reset", a_fs, 0);
      en_a = ($urandom % 6) != 0;
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 800x525 H/V counter pair.
- Adds programmable porch/sync geometry, sync polarity, an internal pixel-clock-enable divider, a run/freeze enable, decoded hsync/vsync/video_on, and line/frame strobes plus a frame counter.
- Sits between the system clock and the pixel/sprite renderers; all downstream drawing logic keys off HControl/VControl and video_on.

Parameters:
- CNT_W, 16, width of HControl/VControl.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- HSYNC_POL, 0, active level of hsync (0 = active-low).
- VSYNC_POL, 0, active level of vsync.
- CLK_DIV, 1, normalCLK cycles per pixel (>=1).
- FRAME_W, 8, width of frame_count.

Ports:
- normalCLK, in, 1, system clock; all logic rising-edge.
- resetN, in, 1, asynchronous active-low reset.
- enable, in, 1, 1 = run; 0 = freeze divider, counters and all outputs.
- pixel_tick, out, 1, one-normalCLK pulse each pixel period.
- HControl, out, CNT_W, horizontal pixel counter, 0..H_TOTAL-1.
- VControl, out, CNT_W, vertical line counter, 0..V_TOTAL-1.
- hsync, out, 1, horizontal sync at HSYNC_POL level.
- vsync, out, 1, vertical sync at VSYNC_POL level.
- video_on, out, 1, high when HControl<H_VISIBLE and VControl<V_VISIBLE.
- line_start, out, 1, one-pixel-period strobe when HControl wraps to 0.
- frame_start, out, 1, one-pixel-period strobe when (H,V) wraps to (0,0).
- frame_count, out, FRAME_W, frames completed; wraps modulo 2^FRAME_W.

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- Elaboration error if CLK_DIV<1, any geometry parameter <1, or H_TOTAL/V_TOTAL > 2^CNT_W.
- Reset (resetN low, asynchronous) sets:
  - divider = 0, HControl = 0, VControl = 0, pixel_tick = 0;
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL;
  - video_on = 1 (decode of (0,0));
  - line_start = 0, frame_start = 0, frame_count = 0.
- Divider: counts 0..CLK_DIV-1 while enable=1. pixel_tick is registered and high for exactly one normalCLK on the cycle after divider==CLK_DIV-1. With CLK_DIV=1, pixel_tick is constantly 1 while enabled.
- Counters advance only on a clock edge where the advance condition (enable=1 and divider==CLK_DIV-1) holds:
  - HControl <= (HControl==H_TOTAL-1) ? 0 : HControl+1.
  - VControl changes only when HControl==H_TOTAL-1: (VControl==V_TOTAL-1) ? 0 : VControl+1.
- Decoded outputs (hsync, vsync, video_on) are registered from next-state counter values, so they are always consistent with the HControl/VControl currently presented (zero relative latency):
  - hsync active when H_VISIBLE+H_FRONT <= HControl <= H_VISIBLE+H_FRONT+H_SYNC-1 (defaults 656..751).
  - vsync active when V_VISIBLE+V_FRONT <= VControl <= V_VISIBLE+V_FRONT+V_SYNC-1 (defaults 490..491); vsync changes only at the H wrap.
- Strobes:
  - line_start = 1 for exactly the pixel period in which HControl==0 after a wrap.
  - frame_start = 1 for the pixel period in which (0,0) is entered by wrap. Not asserted after reset.
  - frame_count increments on the same edge that enters (0,0) by wrap; wraps 2^FRAME_W-1 -> 0.
  - With CLK_DIV>1, strobes hold for CLK_DIV normalCLK cycles (one pixel period).
- enable=0: divider, counters, frame_count and all outputs hold; pixel_tick forced 0 on the next edge. Resuming continues from the held divider phase with no skipped or duplicated pixel.
- Simultaneous H and V wrap on one edge: line_start, frame_start and the frame_count increment occur together.
- Reset asserted mid-line or mid-sync: all outputs return to reset values immediately (asynchronous); counting restarts from (0,0) on the first enabled edge after resetN rises.

Test Plan:
- Defaults, CLK_DIV=1, enable=1, release reset, run 2 frames -> HControl 0..799 wrap, VControl 0..524 wrap; hsync low exactly at H=656..751; vsync low exactly at V=490..491; video_on high only at H<640 and V<480; frame_count 0 -> 1 -> 2; 420000 clocks per frame.
- CLK_DIV=4 -> pixel_tick one clock in every 4; HControl holds each value 4 clocks; line_start high 4 clocks at each H wrap; 3200 clocks per line.
- HSYNC_POL=1, VSYNC_POL=1 -> sync outputs active-high at the same counter windows; idle value 0 after reset.
- Small geometry (H 4/1/2/1, V 3/1/1/1, FRAME_W=2) -> H_TOTAL=8, V_TOTAL=6; frame_count wraps 3 -> 0 on the 4th frame; frame_start coincides with line_start at (0,0).
- Drop enable for 10 clocks at H=700, V=100 -> counters and outputs frozen, pixel_tick 0; resume at H=701 with no skipped pixel.
- Assert resetN low at H=700 (inside hsync) -> hsync immediately goes inactive, counters 0, video_on 1, frame_count 0; no frame_start after release.
